// File: rtl/apb_pkg.sv
// Shared state type, access-size codes and lane helpers for the APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_state_e;

    localparam logic [2:0]  SIZE_B            = 3'b000;
    localparam logic [2:0]  SIZE_H            = 3'b001;
    localparam logic [2:0]  SIZE_W            = 3'b010;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

    function automatic logic [3:0] size_strobe(input logic [2:0] funct3, input logic [1:0] a);
        logic [3:0] strb;
        case (funct3)
            SIZE_B:  strb = 4'b0001 << a;
            SIZE_H:  strb = 4'b0011 << {a[1], 1'b0};
            SIZE_W:  strb = 4'b1111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Narrow stores are replicated across all lanes; the strobe picks the live ones.
    function automatic logic [31:0] size_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            SIZE_B:  lanes = {4{wdata[7:0]}};
            SIZE_H:  lanes = {2{wdata[15:0]}};
            SIZE_W:  lanes = wdata;
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the upper address bits onto a slave slot and its one-hot select.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic [31:12]          addr,
    output logic                  valid,
    output logic [3:0]            slot,
    output logic [NUM_SLAVES-1:0] sel
);

    always_comb begin
        slot  = addr[15:12];
        valid = (addr[31:16] == BASE_ADDR[31:16]) && (32'(slot) < NUM_SLAVES);
        sel   = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = valid && (slot == 4'(i));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Turns single-pulse core data-memory requests into APB SETUP/ACCESS transfers
// with a registered done/error pulse back to the core.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    input  logic [2:0]                  cpu_funct3,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_ready,
    output logic                        cpu_err,
    output logic [31:0]                 paddr,
    output logic [31:0]                 pwdata,
    output logic                        pwrite,
    output logic [3:0]                  pstrb,
    output logic                        penable,
    output logic [NUM_SLAVES-1:0]       psel,
    input  logic [NUM_SLAVES-1:0][31:0] prdata,
    input  logic [NUM_SLAVES-1:0]       pready
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e            state_q, state_d;
    logic [3:0]            slot_q, slot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [31:0]           paddr_d, pwdata_d, rdata_d;
    logic                  pwrite_d, penable_d, ready_d, err_d;
    logic [3:0]            pstrb_d;
    logic [NUM_SLAVES-1:0] psel_d;

    logic                  dec_valid;
    logic [3:0]            dec_slot;
    logic [NUM_SLAVES-1:0] dec_sel;

    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  timeout_hit;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decoder (
        .addr  (cpu_addr[31:12]),
        .valid (dec_valid),
        .slot  (dec_slot),
        .sel   (dec_sel)
    );

    // Only the latched slot's ready/data are looked at; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == 4'(i)) begin
                sel_ready = pready[i];
                sel_rdata = prdata[i];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr;
        pwdata_d  = pwdata;
        pwrite_d  = pwrite;
        pstrb_d   = pstrb;
        psel_d    = psel;
        penable_d = penable;
        rdata_d   = cpu_rdata;
        ready_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (dec_valid) begin
                        state_d  = SETUP;
                        slot_d   = dec_slot;
                        psel_d   = dec_sel;
                        paddr_d  = cpu_addr;
                        pwrite_d = cpu_we;
                        pwdata_d = size_lanes(cpu_funct3, cpu_wdata);
                        pstrb_d  = cpu_we ? size_strobe(cpu_funct3, cpu_addr[1:0]) : 4'b0000;
                    end else begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A slave answering on the last allowed cycle still wins over the timeout.
                if (sel_ready || timeout_hit) begin
                    state_d   = DONE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = !sel_ready;
                    rdata_d   = (sel_ready && !pwrite) ? sel_rdata : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            cnt_q     <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            pstrb     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            pwrite    <= pwrite_d;
            pstrb     <= pstrb_d;
            psel      <= psel_d;
            penable   <= penable_d;
            cpu_rdata <= rdata_d;
            cpu_ready <= ready_d;
            cpu_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table, randomized transfers against a
// behavioural model, plus reset and ignored-request sequences.
module tb_apb_master_bridge;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [2:0]        cpu_funct3;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic              pwrite;
    logic [3:0]        pstrb;
    logic              penable;
    logic [3:0]        psel;
    logic [3:0][31:0]  prdata;
    logic [3:0]        pready;

    int                n_vec = 0;
    int                n_err = 0;

    int                wait_cfg [4];
    logic [31:0]       rd_val   [4];
    logic [3:0]        noise;
    int                acc_cnt;

    typedef struct {
        int          lat;
        int          acc;
        logic [3:0]  sel;
        logic [3:0]  strb;
        logic [31:0] pwd;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          lat;
        int          acc;
        logic [3:0]  sel;
        logic [3:0]  pstrb;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] rdata;
        logic        pwrite;
        logic        err;
        logic        done;
        logic        proto_ok;
        logic        stable_ok;
        logic        pulse_ok;
    } obs_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          w;
        logic [31:0] rv;
        int          lat;
        int          acc;
        logic [3:0]  sel;
        logic [3:0]  strb;
        logic [31:0] pwd;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    apb_master_bridge #(
        .NUM_SLAVES (4),
        .BASE_ADDR  (32'h1000_0000),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_funct3 (cpu_funct3),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_err    (cpu_err),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .pstrb      (pstrb),
        .penable    (penable),
        .psel       (psel),
        .prdata     (prdata),
        .pready     (pready)
    );

    always #5 clk = ~clk;

    // Slave models: selected slave holds pready low for wait_cfg ACCESS cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) acc_cnt <= 0;
        else        acc_cnt <= penable ? acc_cnt + 1 : 0;
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            pready[s] = psel[s] ? (penable && (acc_cnt >= wait_cfg[s])) : noise[s];
            prdata[s] = rd_val[s];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [2:0] f3, input int w, input logic [31:0] rv);
        exp_t e;
        int   n, off, slot;
        bit   mapped;
        slot   = int'((addr >> 12) & 32'hF);
        mapped = (addr[31:16] == 16'h1000) && (slot < 4);
        n      = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        off    = (int'(addr[1:0]) / n) * n;
        e.strb = we ? 4'(((1 << n) - 1) << off) : 4'h0;
        for (int i = 0; i < 4; i++) e.pwd[8*i +: 8] = wdata[8*(i % n) +: 8];
        if (!mapped) begin
            e.acc = 0;
            e.lat = 1;
            e.sel = 4'h0;
            e.err = 1'b1;
        end else begin
            e.acc = (w >= 16) ? 16 : w + 1;
            e.err = (w >= 16);
            e.lat = 2 + e.acc;
            e.sel = 4'(1 << slot);
        end
        e.rdata = (!we && !e.err) ? rv : 32'h0;
        return e;
    endfunction

    task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, output obs_t o);
        bit first;
        o = '{default: 0};
        o.proto_ok  = 1'b1;
        o.stable_ok = 1'b1;
        first = 1;
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_funct3 = f3;
        @(negedge clk);
        cpu_req = 1'b0;
        o.lat = 1;
        while (!cpu_ready && o.lat < 60) begin
            if (psel != 4'h0) begin
                if (!$onehot(psel)) o.proto_ok = 1'b0;
                o.sel |= psel;
                if (first) begin
                    if (penable) o.proto_ok = 1'b0;
                    o.paddr  = paddr;
                    o.pwdata = pwdata;
                    o.pstrb  = pstrb;
                    o.pwrite = pwrite;
                    first = 0;
                end else if (paddr !== o.paddr || pwdata !== o.pwdata ||
                             pstrb !== o.pstrb || pwrite !== o.pwrite) begin
                    o.stable_ok = 1'b0;
                end
                if (penable) o.acc++;
            end else if (penable) begin
                o.proto_ok = 1'b0;
            end
            @(negedge clk);
            o.lat++;
        end
        o.done  = cpu_ready;
        o.err   = cpu_err;
        o.rdata = cpu_rdata;
        if (psel != 4'h0 || penable) o.proto_ok = 1'b0;
        @(negedge clk);
        o.pulse_ok = !cpu_ready && (cpu_rdata === o.rdata);
    endtask

    task automatic check_obs(input string tag, input obs_t o, input exp_t e,
                             input logic we, input logic [31:0] addr);
        chk({tag, ".done"},   32'(o.done),      32'd1);
        chk({tag, ".lat"},    32'(o.lat),       32'(e.lat));
        chk({tag, ".access"}, 32'(o.acc),       32'(e.acc));
        chk({tag, ".psel"},   32'(o.sel),       32'(e.sel));
        chk({tag, ".err"},    32'(o.err),       32'(e.err));
        chk({tag, ".rdata"},  o.rdata,          e.rdata);
        chk({tag, ".proto"},  32'(o.proto_ok),  32'd1);
        chk({tag, ".stable"}, 32'(o.stable_ok), 32'd1);
        chk({tag, ".pulse"},  32'(o.pulse_ok),  32'd1);
        if (e.sel != 4'h0) begin
            chk({tag, ".paddr"},  o.paddr,       addr);
            chk({tag, ".pwrite"}, 32'(o.pwrite), 32'(we));
            chk({tag, ".pstrb"},  32'(o.pstrb),  32'(e.strb));
            if (we) chk({tag, ".pwdata"}, o.pwdata, e.pwd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [11];
        obs_t        o;
        exp_t        e;
        logic [1:0]  slot;
        logic        we;
        logic [31:0] addr, wdata, rv;
        logic [2:0]  f3;
        int          w, r, k, cnt_ready;
        bit          saw2, saw_ready, saw_psel;

        tbl[0]  = '{1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'd2, 0,   32'h0,         3,  1,  4'b0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h1000_2003, 32'h0,         3'd0, 2,   32'h1122_3344, 5,  3,  4'b0100, 4'h0, 32'h0,         1'b0, 32'h1122_3344};
        tbl[2]  = '{1'b0, 32'h2000_0000, 32'h0,         3'd2, 0,   32'h0,         1,  0,  4'b0000, 4'h0, 32'h0,         1'b1, 32'h0};
        tbl[3]  = '{1'b1, 32'h1000_0002, 32'h0000_ABCD, 3'd1, 0,   32'h0,         3,  1,  4'b0001, 4'hC, 32'hABCD_ABCD, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h1000_7000, 32'h0,         3'd2, 0,   32'h0,         1,  0,  4'b0000, 4'h0, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{1'b0, 32'h1000_0010, 32'h0,         3'd2, 255, 32'h7777_0000, 18, 16, 4'b0001, 4'h0, 32'h0,         1'b1, 32'h0};
        tbl[6]  = '{1'b1, 32'h1000_3001, 32'h1234_565A, 3'd0, 1,   32'h0,         4,  2,  4'b1000, 4'h2, 32'h5A5A_5A5A, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h1000_1008, 32'h0,         3'd2, 15,  32'hCAFE_F00D, 18, 16, 4'b0010, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[8]  = '{1'b1, 32'h1000_2002, 32'h8765_4321, 3'd3, 0,   32'h0,         3,  1,  4'b0100, 4'hF, 32'h8765_4321, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 32'h1000_0003, 32'h0000_00AB, 3'd1, 0,   32'h0,         3,  1,  4'b0001, 4'hC, 32'h00AB_00AB, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h1000_3000, 32'h0,         3'd0, 0,   32'h55AA_55AA, 3,  1,  4'b1000, 4'h0, 32'h0,         1'b0, 32'h55AA_55AA};

        for (int s = 0; s < 4; s++) begin
            wait_cfg[s] = 0;
            rd_val[s]   = 32'hA0A0_0000 + 32'(s);
        end
        noise      = 4'h0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        cpu_funct3 = 3'd0;
        reset      = 1'b0;

        #3;
        chk("reset.psel",      32'(psel),      32'h0);
        chk("reset.penable",   32'(penable),   32'h0);
        chk("reset.cpu_ready", 32'(cpu_ready), 32'h0);
        chk("reset.cpu_err",   32'(cpu_err),   32'h0);
        chk("reset.cpu_rdata", cpu_rdata,      32'h0);
        chk("reset.paddr",     paddr,          32'h0);
        chk("reset.pstrb",     32'(pstrb),     32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            slot           = tbl[i].addr[13:12];
            wait_cfg[slot] = tbl[i].w;
            rd_val[slot]   = tbl[i].rv;
            noise          = 4'hF;
            run_xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, o);
            e.lat   = tbl[i].lat;
            e.acc   = tbl[i].acc;
            e.sel   = tbl[i].sel;
            e.strb  = tbl[i].strb;
            e.pwd   = tbl[i].pwd;
            e.err   = tbl[i].err;
            e.rdata = tbl[i].rdata;
            check_obs($sformatf("vec%0d", i), o, e, tbl[i].we, tbl[i].addr);
        end

        for (int i = 0; i < 80; i++) begin
            r    = $urandom_range(0, 9);
            slot = 2'($urandom_range(0, 3));
            if (r == 0) begin
                addr = $urandom;
                if (addr[31:16] == 16'h1000) addr[31] = 1'b1;
            end else if (r == 1) begin
                addr = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
            end else begin
                addr = {16'h1000, 2'b00, slot, 12'($urandom)};
            end
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 3);
            else if (r == 7) w = 15;
            else if (r == 8) w = 16;
            else             w = $urandom_range(17, 40);
            we    = 1'($urandom);
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            rv    = $urandom;
            wait_cfg[addr[13:12]] = w;
            rd_val[addr[13:12]]   = rv;
            noise = 4'($urandom);
            e = model(we, addr, wdata, f3, w, rv);
            run_xfer(we, addr, wdata, f3, o);
            check_obs($sformatf("rnd%0d", i), o, e, we, addr);
        end

        // Reset while a transfer sits in ACCESS.
        wait_cfg[0] = 255;
        noise       = 4'h0;
        rd_val[1]   = 32'h0BAD_F00D;
        wait_cfg[1] = 0;
        run_xfer(1'b0, 32'h1000_1000, 32'h0, 3'd2, o);
        chk("pre_rst.rdata", o.rdata, 32'h0BAD_F00D);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h1000_0000;
        cpu_funct3 = 3'd2;
        @(negedge clk);
        cpu_req = 1'b0;
        k = 0;
        while (!penable && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid.reached_access", 32'(penable), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid.psel",      32'(psel),      32'h0);
        chk("rst_mid.penable",   32'(penable),   32'h0);
        chk("rst_mid.pwrite",    32'(pwrite),    32'h0);
        chk("rst_mid.paddr",     paddr,          32'h0);
        chk("rst_mid.pstrb",     32'(pstrb),     32'h0);
        chk("rst_mid.cpu_rdata", cpu_rdata,      32'h0);
        chk("rst_mid.cpu_ready", 32'(cpu_ready), 32'h0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        saw_ready = 0;
        saw_psel  = 0;
        repeat (25) begin
            @(negedge clk);
            if (cpu_ready) saw_ready = 1;
            if (psel != 4'h0) saw_psel = 1;
        end
        chk("rst_mid.no_ready_after", 32'(saw_ready), 32'd0);
        chk("rst_mid.bus_idle_after", 32'(saw_psel),  32'd0);

        // Requests during ACCESS and DONE must be dropped.
        wait_cfg[1] = 3;
        noise       = 4'h0;
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h1000_1000;
        cpu_wdata  = 32'h1;
        cpu_funct3 = 3'd2;
        @(negedge clk);
        cpu_req = 1'b0;
        k = 0;
        while (!penable && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("ign.reached_access", 32'(penable), 32'd1);
        cpu_req  = 1'b1;
        cpu_addr = 32'h1000_2000;
        cnt_ready = 0;
        saw2      = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (cpu_ready) begin
                cnt_ready++;
                cpu_req = 1'b1;
            end
            if (psel[2]) saw2 = 1;
        end
        cpu_req = 1'b0;
        chk("ign.one_completion", 32'(cnt_ready), 32'd1);
        chk("ign.no_second_xfer", 32'(saw2),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
